// File: rtl/misr_pkg.sv
// rtl/misr_pkg.sv - shared MISR state enum, polynomial taps and next-signature function
//
// Contents:
//   misr_state_t  FSM states of the signature checker
//   POLY_TAPS     x^32+x^16+x^11+x^4+1 feedback taps (bit 0 is the wrap-around)
//   misr_next     one-word signature update, shared with generator-side models
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WAIT_EXP,
    DONE
  } misr_state_t;

  localparam logic [31:0] POLY_TAPS = 32'h0001_0811;

  // Shift left by one, fold the outgoing MSB back into the tap positions,
  // then mix in the data word bit-for-bit.
  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ ({32{s[31]}} & POLY_TAPS) ^ d;
  endfunction

endpackage

// File: rtl/misr32_step.sv
// rtl/misr32_step.sv - combinational 32-bit MISR next-state
//
// Ports:
//   sig       current signature
//   din       data word absorbed this step
//   sig_next  signature after absorbing din
module misr32_step
  import misr_pkg::*;
(
  input  logic [31:0] sig,
  input  logic [31:0] din,
  output logic [31:0] sig_next
);

  assign sig_next = misr_next(sig, din);

endmodule

// File: rtl/misr_sig_checker.sv
// rtl/misr_sig_checker.sv - frame signature accumulator and expected-signature checker
//
// Optional feature macro: MISR_CHK_TIMEOUT_EN (adds WAIT_EXP timeout and tmo output).
//
// Parameters:
//   SEED     signature loaded on start
//   CNT_W    width of the saturating word counter
//   TMO_CYC  cycles allowed in WAIT_EXP before a timeout verdict (timeout build only)
// Ports:
//   CK, RESET            clock (rising edge), synchronous active-high reset
//   start                begin a frame; honoured in IDLE or DONE
//   din_valid/din_ready  word handshake; din_ready is high only in ACCUM
//   din, din_last        data word and final-word marker
//   exp_sig, exp_valid   expected signature, consumed in WAIT_EXP
//   busy                 frame in progress (ACCUM or WAIT_EXP)
//   done                 one-cycle verdict pulse
//   pass, fail           sticky verdict until next start/RESET
//   sig_out              current signature register
//   word_cnt             words accepted this frame, saturating
//   tmo                  timeout flag (timeout build only)
module misr_sig_checker
  import misr_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h0000_0000,
  parameter int          CNT_W   = 16,
  parameter int          TMO_CYC = 1024
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din,
  input  logic             din_last,
  input  logic [31:0]      exp_sig,
  input  logic             exp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      sig_out,
  output logic [CNT_W-1:0] word_cnt
`ifdef MISR_CHK_TIMEOUT_EN
  ,
  output logic             tmo
`endif
);

  if (CNT_W < 1 || TMO_CYC < 1) begin : g_param_chk
    $error("misr_sig_checker: CNT_W and TMO_CYC must be at least 1");
  end

  misr_state_t state;
  logic [31:0] sig_next;
  logic        hs;

  // din_ready is registered and high exactly while in ACCUM, so it doubles
  // as the state qualifier for the handshake.
  assign hs = din_valid & din_ready;

  misr32_step u_step (
    .sig      (sig_out),
    .din      (din),
    .sig_next (sig_next)
  );

`ifdef MISR_CHK_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge CK) begin
    if (RESET) begin
      state     <= IDLE;
      sig_out   <= '0;
      word_cnt  <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
`ifdef MISR_CHK_TIMEOUT_EN
      tmo       <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= ACCUM;
            sig_out   <= SEED;
            word_cnt  <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
`ifdef MISR_CHK_TIMEOUT_EN
            tmo       <= 1'b0;
`endif
          end
        end
        ACCUM: begin
          if (hs) begin
            sig_out <= sig_next;
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
            if (din_last) begin
              state     <= WAIT_EXP;
              din_ready <= 1'b0;
`ifdef MISR_CHK_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        WAIT_EXP: begin
          if (exp_valid) begin
            state <= DONE;
            pass  <= (sig_out == exp_sig);
            fail  <= (sig_out != exp_sig);
            done  <= 1'b1;
            busy  <= 1'b0;
          end
`ifdef MISR_CHK_TIMEOUT_EN
          // Counter starts at 0 on entry, so the verdict lands TMO_CYC
          // cycles after WAIT_EXP is entered.
          else if (tmo_cnt == TMO_LAST) begin
            state <= DONE;
            pass  <= 1'b0;
            fail  <= 1'b1;
            tmo   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/misr_sig_checker.md
MISR_SIG_CHECKER -- requirements
Module: misr_sig_checker

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0000, initial signature loaded on start.
REQ-002 SHALL have parameter CNT_W, default 16, width of the word counter.
REQ-003 SHALL have parameter TMO_CYC, default 1024, cycles allowed for exp_valid after the last word (used only with MISR_CHK_TIMEOUT_EN).
REQ-004 SHALL have ports:
  CK  input  1  single clock, rising edge.
  RESET  input  1  synchronous, active-high reset.
  start  input  1  begin a new frame; loads SEED, honoured in IDLE or DONE only.
  din_valid  input  1  data word offered.
  din_ready  output  1  block accepts a word this cycle.
  din  input  32  data word; bit i feeds signature bit i.
  din_last  input  1  qualifies the final word of the frame.
  exp_sig  input  32  expected signature.
  exp_valid  input  1  exp_sig is valid; consumed in WAIT_EXP.
  busy  output  1  FSM not in IDLE/DONE.
  done  output  1  one-cycle pulse when the verdict is produced.
  pass  output  1  sticky verdict: signature matched.
  fail  output  1  sticky verdict: mismatch (or timeout).
  sig_out  output  32  current signature register.
  word_cnt  output  CNT_W  words accepted in the current frame, saturating.

Function
REQ-005 The signature register S SHALL update only on a din handshake (din_valid and din_ready).
REQ-006 The update SHALL be S'[0]=S[31]^din[0], and S'[i]=S[i-1]^din[i] for i not in {0,4,11,16}.
REQ-007 The update SHALL also XOR S[31] into positions 4, 11 and 16 (polynomial x^32+x^16+x^11+x^4+1): S'[i]=S[i-1]^S[31]^din[i] for those positions.
REQ-008 The FSM SHALL have states IDLE, ACCUM, WAIT_EXP, DONE.
REQ-009 IDLE->ACCUM on start: S<=SEED, word_cnt<=0, pass<=0, fail<=0.
REQ-010 In ACCUM, din_ready SHALL be 1; in all other states din_ready SHALL be 0.
REQ-011 In ACCUM, a handshake with din_last=1 SHALL go to WAIT_EXP, with S holding the updated value.
REQ-012 In WAIT_EXP, exp_valid=1 SHALL go to DONE, set pass=(S==exp_sig) and fail=!pass, and pulse done for exactly that transition cycle's following cycle (done registered, latency 1 from exp_valid).
REQ-013 In DONE, pass and fail SHALL hold.
REQ-014 start in DONE SHALL behave as in IDLE (REQ-009), so back-to-back frames need no idle cycle.
REQ-015 start while in ACCUM or WAIT_EXP SHALL be ignored.
REQ-016 exp_valid outside WAIT_EXP SHALL be ignored.
REQ-017 A handshake with din_last=1 SHALL still apply the word to S.
REQ-018 word_cnt SHALL increment per handshake and saturate at all-ones.
REQ-019 The latency from the last handshake to done SHALL be at least 2 cycles (WAIT_EXP, then compare).
REQ-020 A zero-word frame SHALL NOT be supported; the first handshake always follows start.

Reset
REQ-021 RESET=1 at a clock edge SHALL force: state IDLE, S=0, word_cnt=0, din_ready=0, busy=0, done=0, pass=0, fail=0.
REQ-022 RESET SHALL override start and handshakes in the same cycle.
REQ-023 RESET mid-frame SHALL abort the frame with no done pulse.

Configuration
REQ-024 Macro MISR_CHK_TIMEOUT_EN defined: a counter SHALL run in WAIT_EXP. Reaching TMO_CYC cycles without exp_valid SHALL go to DONE with fail=1, pass=0 and a done pulse. An output tmo (1 bit, sticky until next start/RESET) SHALL flag the timeout.
REQ-025 Macro absent: WAIT_EXP SHALL wait indefinitely, with no counter and no tmo port.

Structure
REQ-026 Package misr_pkg SHALL hold the state enum, the POLY_TAPS constant (32'h0001_0811), and a function misr_next(S, din) used by both this block and the generator-side model.
REQ-027 The signature update SHALL be one sub-module, misr32_step (combinational next-state); the FSM, counters and compare SHALL sit in misr_sig_checker.

Verification
REQ-028 SEED=0; one word din=32'h0000_0001 with last; exp_sig=32'h0000_0001 -> S=1, done pulse, pass=1, fail=0.
REQ-029 SEED=0; words 32'h8000_0000 then 32'h0 (last) -> after word 1 S=32'h8000_0000, after word 2 S=32'h0001_0811; exp 32'h0001_0811 -> pass=1.
REQ-030 Same frame as REQ-029, exp_sig=32'h0001_0810 -> fail=1, pass=0, done 1 cycle.
REQ-031 RESET asserted after 3 of 5 words -> IDLE, S=0, word_cnt=0, no done; new start then 5 words matches the reference model.
REQ-032 din_valid held high in WAIT_EXP/DONE -> no handshake, S and word_cnt unchanged; start in DONE -> ACCUM next cycle with S=SEED.
REQ-033 With MISR_CHK_TIMEOUT_EN, TMO_CYC=8, exp_valid never asserted -> done 8 cycles after entering WAIT_EXP, fail=1, tmo=1.
